// File: rtl/pattern_seq_detector.sv
// pattern_seq_detector
// Serial pattern detector with a run-time loadable pattern, length and
// overlap mode. Each qualified input bit is shifted into a history
// register. The Mealy output y pulses in the same cycle as the last
// pattern bit whenever the most recent len bits equal the active pattern.
//
// Optional feature: define PATTERN_SEQ_DET_MATCH_CNT_EN to add the
// saturating match counter output match_cnt.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous active-high reset
//   in_valid     qualifies in
//   in           serial data bit
//   cfg_we       one-cycle configuration load strobe
//   cfg_pattern  new pattern; bit [len-1] arrives first, bit [0] last
//   cfg_len      new pattern length (clamped to N, 0 disables matching)
//   cfg_ovl      new overlap mode (0 non-overlapping, 1 overlapping)
//   y            combinational match pulse
//   fill         registered count of valid bits accumulated toward a match
//   match_cnt    saturating match count (only with the macro defined)
module pattern_seq_detector #(
  parameter int             N       = 8,
  parameter int             LW      = $clog2(N + 1),
  parameter logic [N-1:0]   DEF_PAT = N'(8'b0001_1011),
  parameter int             DEF_LEN = 5,
  parameter bit             DEF_OVL = 1'b0,
  parameter int             CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in,
  input  logic              cfg_we,
  input  logic [N-1:0]      cfg_pattern,
  input  logic [LW-1:0]     cfg_len,
  input  logic              cfg_ovl,
  output logic              y,
  output logic [LW-1:0]     fill
`ifdef PATTERN_SEQ_DET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]  match_cnt
`endif
);

  // The oldest history bit would be shifted out before it is ever compared,
  // so only N-1 bits are stored; the current input completes the window.
  logic [N-2:0]  r_hist;
  logic [LW-1:0] r_fill;
  logic [LW-1:0] r_len;
  logic [N-1:0]  r_pat;
  logic          r_ovl;

  logic [N-1:0]  w_win;
  logic [N-1:0]  w_mask;
  logic          w_fill_ok;
  logic          w_match;
  logic [LW-1:0] w_len_ld;

  // Mask selecting the low l bits of the comparison window.
  function automatic logic [N-1:0] len_mask(input logic [LW-1:0] l);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      m[i] = (LW'(i) < l);
    end
    return m;
  endfunction

  // Match evaluation and configuration length clamp.
  always_comb begin
    w_win     = {r_hist, in};
    w_mask    = len_mask(r_len);
    // len=0 disables matching; guarding it also keeps len-1 from wrapping.
    w_fill_ok = (r_len != LW'(0)) && (r_fill >= (r_len - LW'(1)));
    w_match   = in_valid & ~cfg_we & w_fill_ok &
                ((w_win & w_mask) == (r_pat & w_mask));
    if (cfg_len > LW'(N)) begin
      w_len_ld = LW'(N);
    end else begin
      w_len_ld = cfg_len;
    end
  end

  assign y    = w_match;
  assign fill = r_fill;

  // History, fill and active configuration state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= DEF_PAT;
      r_len  <= LW'(DEF_LEN);
      r_ovl  <= DEF_OVL;
    end else if (cfg_we) begin
      // Configuration wins over a coincident data bit, which is dropped.
      r_pat  <= cfg_pattern;
      r_len  <= w_len_ld;
      r_ovl  <= cfg_ovl;
      r_hist <= '0;
      r_fill <= '0;
    end else if (in_valid) begin
      r_hist <= w_win[N-2:0];
      if (w_match && !r_ovl) begin
        // Consume the matched bits so none of them seeds a later match.
        r_fill <= '0;
      end else if (r_fill < r_len) begin
        r_fill <= r_fill + LW'(1);
      end else begin
        r_fill <= r_fill;
      end
    end else begin
      r_hist <= r_hist;
      r_fill <= r_fill;
    end
  end

`ifdef PATTERN_SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] r_match_cnt;

  // Saturating count of match pulses, cleared by reset and by a config load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_match_cnt <= '0;
    end else if (cfg_we) begin
      r_match_cnt <= '0;
    end else if (w_match && (r_match_cnt != {CNT_W{1'b1}})) begin
      r_match_cnt <= r_match_cnt + CNT_W'(1);
    end else begin
      r_match_cnt <= r_match_cnt;
    end
  end

  assign match_cnt = r_match_cnt;
`endif

endmodule
